// File: rtl/grid_scanner.sv
// Display-side scanner for the Life grid: snapshots a grid over valid/ready and
// drives a multiplexed LED matrix row by row with dwell and blanking.
module grid_scanner #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [ROWS*COLS-1:0]              grid_in,
  input  logic                              grid_valid,
  output logic                              grid_ready,
  output logic [ROWS-1:0]                   row_sel,
  output logic [COLS-1:0]                   col_data,
  output logic                              blank,
  output logic                              frame_done,
  output logic [$clog2(ROWS*COLS+1)-1:0]    live_count
);

  localparam int RW   = $clog2(ROWS);
  localparam int DMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam int LW   = $clog2(ROWS*COLS+1);

  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS-1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL-1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK-1 : 0);

  typedef enum logic [1:0] {IDLE, SHOW, BLNK} state_t;

  state_t                 state_r, state_nxt_s;
  logic [RW-1:0]          row_r, row_nxt_s;
  logic [CW-1:0]          dwell_r, dwell_nxt_s;
  logic [ROWS*COLS-1:0]   snap_r, snap_nxt_s;
  logic                   last_s;
  logic                   accept_s;

  function automatic logic is_last(state_t s, logic [RW-1:0] r, logic [CW-1:0] d);
    logic res;
    if (BLANK == 0) begin
      res = (s == SHOW) && (r == ROW_LAST) && (d == DWELL_LAST);
    end else begin
      res = (s == BLNK) && (r == ROW_LAST) && (d == BLANK_LAST);
    end
    return res;
  endfunction

  function automatic logic [COLS-1:0] get_row(logic [ROWS*COLS-1:0] g, logic [RW-1:0] r);
    int base;
    base = ROWS*COLS - 1 - int'(r)*COLS;
    return g[base -: COLS];
  endfunction

  function automatic logic [LW-1:0] popcount(logic [ROWS*COLS-1:0] g);
    logic [LW-1:0] n;
    n = '0;
    for (int i = 0; i < ROWS*COLS; i++) begin
      n = n + LW'(g[i]);
    end
    return n;
  endfunction

  assign last_s     = is_last(state_r, row_r, dwell_r);
  assign grid_ready = !reset && enable && ((state_r == IDLE) || last_s);
  assign accept_s   = grid_valid && grid_ready;

  // Next scan position and snapshot; frame boundaries reload, restart or park in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    row_nxt_s   = row_r;
    dwell_nxt_s = dwell_r;
    snap_nxt_s  = snap_r;
    if ((state_r == IDLE) || last_s) begin
      row_nxt_s   = '0;
      dwell_nxt_s = '0;
      if (accept_s) begin
        snap_nxt_s  = grid_in;
        state_nxt_s = SHOW;
      end else if ((state_r != IDLE) && enable) begin
        state_nxt_s = SHOW;
      end else begin
        state_nxt_s = IDLE;
      end
    end else begin
      case (state_r)
        SHOW: begin
          if (dwell_r == DWELL_LAST) begin
            dwell_nxt_s = '0;
            if (BLANK > 0) begin
              state_nxt_s = BLNK;
            end else begin
              row_nxt_s = row_r + RW'(1);
            end
          end else begin
            dwell_nxt_s = dwell_r + CW'(1);
          end
        end
        BLNK: begin
          if (dwell_r == BLANK_LAST) begin
            dwell_nxt_s = '0;
            row_nxt_s   = row_r + RW'(1);
            state_nxt_s = SHOW;
          end else begin
            dwell_nxt_s = dwell_r + CW'(1);
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State registers; outputs are derived from the next position so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      row_r      <= '0;
      dwell_r    <= '0;
      snap_r     <= '0;
      row_sel    <= '0;
      col_data   <= '0;
      blank      <= 1'b0;
      frame_done <= 1'b0;
      live_count <= '0;
    end else begin
      state_r    <= state_nxt_s;
      row_r      <= row_nxt_s;
      dwell_r    <= dwell_nxt_s;
      snap_r     <= snap_nxt_s;
      row_sel    <= (state_nxt_s == SHOW) ? ({{(ROWS-1){1'b0}}, 1'b1} << row_nxt_s) : '0;
      col_data   <= (state_nxt_s == SHOW) ? get_row(snap_nxt_s, row_nxt_s) : '0;
      blank      <= (state_nxt_s == BLNK);
      frame_done <= is_last(state_nxt_s, row_nxt_s, dwell_nxt_s);
      live_count <= accept_s ? popcount(grid_in) : live_count;
    end
  end

endmodule

// File: tb/tb_grid_scanner.sv
// Bench for grid_scanner: two instances (BLANK=1 and BLANK=0, DWELL=2) checked
// every cycle against a frame-position model, plus directed table checkpoints.
module tb_grid_scanner;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b1;
  logic         grid_valid = 1'b0;
  logic [255:0] grid_in = '0;

  logic         gr [2];
  logic [15:0]  rs [2];
  logic [15:0]  cd [2];
  logic         bl [2];
  logic         fd [2];
  logic [8:0]   lc [2];

  int total = 0;
  int bad   = 0;
  int cur   = 0;

  // model: active flag, cycle position within frame, snapshot, population
  bit           m_act  [2];
  int           m_k    [2];
  logic [255:0] m_snap [2];
  int           m_live [2];

  typedef struct {
    int          at;
    logic [15:0] rs;
    logic [15:0] cd;
    logic        bl;
    logic        fd;
    logic        gr;
    logic [8:0]  lc;
  } vec_t;

  vec_t tbl [12];

  grid_scanner #(.ROWS(16), .COLS(16), .DWELL(2), .BLANK(1)) dut_b1 (
    .clk(clk), .reset(reset), .enable(enable), .grid_in(grid_in), .grid_valid(grid_valid),
    .grid_ready(gr[0]), .row_sel(rs[0]), .col_data(cd[0]), .blank(bl[0]),
    .frame_done(fd[0]), .live_count(lc[0]));

  grid_scanner #(.ROWS(16), .COLS(16), .DWELL(2), .BLANK(0)) dut_b0 (
    .clk(clk), .reset(reset), .enable(enable), .grid_in(grid_in), .grid_valid(grid_valid),
    .grid_ready(gr[1]), .row_sel(rs[1]), .col_data(cd[1]), .blank(bl[1]),
    .frame_done(fd[1]), .live_count(lc[1]));

  always #5 clk = ~clk;

  function automatic int per(int i);
    return (i == 0) ? 3 : 2;
  endfunction

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_ready(int i);
    if (reset) return 1'b0;
    return enable && (!m_act[i] || (m_k[i] == 16*per(i) - 1));
  endfunction

  task automatic model_step(int i, logic rdy);
    if (reset) begin
      m_act[i] = 1'b0; m_k[i] = 0; m_snap[i] = '0; m_live[i] = 0;
    end else if (!m_act[i]) begin
      if (rdy && grid_valid) begin
        m_act[i] = 1'b1; m_k[i] = 0; m_snap[i] = grid_in; m_live[i] = $countones(grid_in);
      end
    end else if (m_k[i] == 16*per(i) - 1) begin
      m_k[i] = 0;
      if (rdy && grid_valid) begin
        m_snap[i] = grid_in; m_live[i] = $countones(grid_in);
      end else if (!enable) begin
        m_act[i] = 1'b0;
      end
    end else begin
      m_k[i] = m_k[i] + 1;
    end
  endtask

  task automatic check_outputs(int i);
    logic [15:0]  ers, ecd;
    logic         ebl, efd;
    logic [255:0] tmp;
    int p, r, ph;
    ers = '0; ecd = '0; ebl = 1'b0; efd = 1'b0;
    p = per(i);
    if (m_act[i]) begin
      r  = m_k[i] / p;
      ph = m_k[i] % p;
      if (ph < 2) begin
        ers = 16'h0001 << r;
        tmp = m_snap[i] >> ((15 - r) * 16);
        ecd = tmp[15:0];
      end else begin
        ebl = 1'b1;
      end
      efd = (m_k[i] == 16*p - 1);
    end
    chk($sformatf("row_sel%0d", i), 256'(rs[i]), 256'(ers));
    chk($sformatf("col_data%0d", i), 256'(cd[i]), 256'(ecd));
    chk($sformatf("blank%0d", i), 256'(bl[i]), 256'(ebl));
    chk($sformatf("frame_done%0d", i), 256'(fd[i]), 256'(efd));
    chk($sformatf("live_count%0d", i), 256'(lc[i]), 256'(m_live[i]));
  endtask

  task automatic tick();
    logic rdy [2];
    #1;
    for (int i = 0; i < 2; i++) begin
      rdy[i] = model_ready(i);
      chk($sformatf("grid_ready%0d", i), 256'(gr[i]), 256'(rdy[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, rdy[i]);
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i);
    cur++;
  endtask

  function automatic logic [255:0] rand_grid();
    logic [255:0] g, m;
    for (int w = 0; w < 8; w++) begin
      g[w*32 +: 32] = $urandom;
      m[w*32 +: 32] = $urandom;
    end
    return ($urandom_range(0, 1) == 0) ? (g & m) : g;
  endfunction

  initial begin
    logic [255:0] g_test;
    logic [255:0] ones;
    logic         seen;

    tbl[0]  = '{1,  16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd9};
    tbl[1]  = '{2,  16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd9};
    tbl[2]  = '{3,  16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 9'd9};
    tbl[3]  = '{4,  16'h0002, 16'h2000, 1'b0, 1'b0, 1'b0, 9'd9};
    tbl[4]  = '{13, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd9};
    tbl[5]  = '{16, 16'h0020, 16'h2000, 1'b0, 1'b0, 1'b0, 9'd9};
    tbl[6]  = '{37, 16'h1000, 16'h0010, 1'b0, 1'b0, 1'b0, 9'd9};
    tbl[7]  = '{47, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 9'd9};
    tbl[8]  = '{48, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 9'd9};
    tbl[9]  = '{49, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 9'd256};
    tbl[10] = '{96, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 9'd256};
    tbl[11] = '{97, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 9'd256};

    g_test = '0;
    for (int r = 0; r < 16; r++) begin
      if ((r >= 1 && r <= 3) || (r >= 5 && r <= 7)) g_test[255 - r*16 -: 16] = 16'h2000;
      if (r >= 12 && r <= 14) g_test[255 - r*16 -: 16] = 16'h0010;
    end
    ones = '1;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_k[i] = 0; m_snap[i] = '0; m_live[i] = 0;
    end

    // reset, then idle with enable=1
    reset = 1'b1; enable = 1'b1; grid_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    chk("idle_row_sel", 256'(rs[0]), 256'(16'h0000));
    chk("idle_ready", 256'(gr[0]), 256'(1'b1));

    // directed frame sequence: accept at cycle 0
    cur = 0;
    while (cur < 100) begin
      grid_valid = (cur == 0) || (cur >= 10 && cur <= 20) || (cur == 48);
      grid_in    = (cur == 0) ? g_test : ones;
      tick();
      for (int j = 0; j < 12; j++) begin
        if (tbl[j].at == cur) begin
          chk($sformatf("t%0d_row_sel", cur), 256'(rs[0]), 256'(tbl[j].rs));
          chk($sformatf("t%0d_col_data", cur), 256'(cd[0]), 256'(tbl[j].cd));
          chk($sformatf("t%0d_blank", cur), 256'(bl[0]), 256'(tbl[j].bl));
          chk($sformatf("t%0d_frame_done", cur), 256'(fd[0]), 256'(tbl[j].fd));
          chk($sformatf("t%0d_grid_ready", cur), 256'(gr[0]), 256'(tbl[j].gr));
          chk($sformatf("t%0d_live_count", cur), 256'(lc[0]), 256'(tbl[j].lc));
        end
      end
      if (cur == 3) chk("b0_row1_sel", 256'(rs[1]), 256'(16'h0002));
      if (cur == 3) chk("b0_row1_col", 256'(cd[1]), 256'(16'h2000));
      if (cur == 32) chk("b0_frame_done_32", 256'(fd[1]), 256'(1'b1));
    end
    grid_valid = 1'b0;

    // enable drop during row 5: frame completes, then idle
    for (int n = 0; n < 60 && m_k[0] != 15; n++) tick();
    chk("reach_row5", 256'(m_k[0]), 256'(15));
    enable = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      tick();
      seen = fd[0];
    end
    chk("frame_done_after_disable", 256'(seen), 256'(1'b1));
    tick();
    chk("disabled_row_sel", 256'(rs[0]), 256'(16'h0000));
    chk("disabled_ready", 256'(gr[0]), 256'(1'b0));
    for (int n = 0; n < 40; n++) tick();
    enable = 1'b1;
    tick();

    // reset in the middle of row 8
    grid_valid = 1'b1; grid_in = rand_grid();
    tick();
    grid_valid = 1'b0;
    for (int n = 0; n < 60 && m_k[0] != 24; n++) tick();
    chk("reach_row8", 256'(rs[0]), 256'(16'h0100));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_row_sel", 256'(rs[0]), 256'(16'h0000));
    chk("rst_col_data", 256'(cd[0]), 256'(16'h0000));
    chk("rst_live", 256'(lc[0]), 256'(9'd0));
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      enable     = ($urandom_range(0, 15) != 0);
      grid_valid = ($urandom_range(0, 2) == 0);
      reset      = ($urandom_range(0, 499) == 0);
      grid_in    = rand_grid();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
